// File: rtl/mc_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : mc_control_fsm
// Purpose  : Multicycle MIPS main control FSM with memory handshake timeout.
//            Optional trap state for illegal opcodes: define MC_CTRL_TRAP_EN.
// Revision : 1.0
// ============================================================================
module mc_control_fsm #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode_i,
    input  logic [5:0] func_i,
    input  logic       mem_ready_i,
    output logic [2:0] ula_operation_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic [1:0] pc_src_o,
    output logic       ir_write_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       i_or_d_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       mem_err_o,
    output logic       trap_o
);

    localparam int              CNT_W    = $clog2(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_WB_R     = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_I     = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JR       = 4'd12,
        S_ILLEGAL  = 4'd13
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       opcode_q, opcode_d;
    logic             mem_err_q, mem_err_d;
    logic             mem_state;
    logic             timeout;
    logic             trap_d;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout   = mem_state && !mem_ready_i && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cnt_q     <= '0;
            opcode_q  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            opcode_q  <= opcode_d;
            mem_err_q <= mem_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        mem_err_d = timeout;
        case (state_q)
            S_FETCH:    if (mem_ready_i) state_d = S_DECODE;
            S_DECODE: begin
                opcode_d = opcode_i;
                casez (opcode_i)
                    6'b000000:           state_d = (func_i == 6'b001000) ? S_JR : S_EXEC_R;
                    6'b100011, 6'b101011: state_d = S_MEM_ADDR;
                    6'b000100, 6'b000101: state_d = S_BRANCH;
                    6'b000010:           state_d = S_JUMP;
                    6'b001000, 6'b001010,
                    6'b0011??:           state_d = S_EXEC_I;
                    default:             state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            // opcode bit 3 separates sw (101011) from lw (100011)
            S_MEM_ADDR: state_d = opcode_q[3] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready_i) state_d = S_WB_MEM;
            S_MEM_WR:   if (mem_ready_i) state_d = S_FETCH;
`ifdef MC_CTRL_TRAP_EN
            S_ILLEGAL:  state_d = S_ILLEGAL;
`else
            S_ILLEGAL:  state_d = S_FETCH;
`endif
            default:    state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_FETCH;
    end

    // Wait counter restarts on every entry into a state, including FETCH re-entry after timeout
    always_comb begin
        cnt_d = cnt_q;
        if (timeout || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (mem_state && !mem_ready_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        ula_operation_o = 3'b000;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'b00;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        pc_src_o        = 2'b00;
        ir_write_o      = 1'b0;
        mem_req_o       = 1'b0;
        mem_we_o        = 1'b0;
        i_or_d_o        = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        trap_d          = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
            end
            S_DECODE: alu_src_b_o = 2'b11;
            S_EXEC_R: begin
                alu_src_a_o     = 1'b1;
                ula_operation_o = 3'b010;
            end
            S_WB_R: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                case (opcode_q)
                    6'b001010: ula_operation_o = 3'b011;
                    6'b001100: ula_operation_o = 3'b100;
                    6'b001101: ula_operation_o = 3'b101;
                    6'b001110: ula_operation_o = 3'b110;
                    6'b001111: ula_operation_o = 3'b111;
                    default:   ula_operation_o = 3'b000;
                endcase
            end
            S_WB_I:     reg_write_o = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
            end
            S_MEM_RD: begin
                mem_req_o = 1'b1;
                i_or_d_o  = 1'b1;
            end
            S_MEM_WR: begin
                mem_req_o = 1'b1;
                mem_we_o  = 1'b1;
                i_or_d_o  = 1'b1;
            end
            S_WB_MEM: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                ula_operation_o = 3'b001;
                pc_write_cond_o = 1'b1;
                pc_src_o        = 2'b01;
                branch_ne_o     = opcode_q[0];
            end
            S_JUMP: begin
                pc_write_o = 1'b1;
                pc_src_o   = 2'b10;
            end
            S_JR: begin
                pc_write_o      = 1'b1;
                pc_src_o        = 2'b11;
                ula_operation_o = 3'b010;
            end
            S_ILLEGAL:  trap_d = 1'b1;
            default: ;
        endcase
    end

    assign mem_err_o = mem_err_q;

`ifdef MC_CTRL_TRAP_EN
    assign trap_o = trap_d;
`else
    logic unused_trap;
    assign unused_trap = trap_d;
    assign trap_o      = 1'b0;
`endif

endmodule
`default_nettype wire
